wb_mem_slave: RTL and testbench
===============================

// Module: wb_mem_slave
// PURPOSE
//  Synthesizable Wishbone B3 classic slave: byte-enabled 64-bit memory with programmable wait
//  states, error response and a no-ack hole. Sits directly downstream of the Wishbone master BFM
//  and is the target the bench drives with WRITE/READ/IDLE/CFG_DELAY/CFG_TIMEOUT operations.
//  Exercises BFM delay, error and timeout handling against a known RTL responder.
// PARAMETERS
//  DEPTH_LOG2  8             memory depth = 2**DEPTH_LOG2 64-bit words
//  BASE_ADDR   32'h0000_0000 byte base address; low 3+DEPTH_LOG2 bits must be zero
//  HOLE_ADDR   32'hFFFF_FFF8 byte address that never acknowledges (timeout target)
// PORTS
//  clk        in   1   single clock, all logic rising-edge
//  rst        in   1   synchronous, active-high reset
//  wb_cyc_i   in   1   bus cycle valid
//  wb_stb_i   in   1   strobe
//  wb_we_i    in   1   1 = write, 0 = read
//  wb_adr_i   in   32  byte address
//  wb_sel_i   in   8   byte enables, bit n -> dat[8n+7:8n]
//  wb_dat_i   in   64  write data
//  wb_dat_o   out  64  read data, valid while wb_ack_o=1
//  wb_ack_o   out  1   one-cycle normal termination
//  wb_err_o   out  1   one-cycle error termination
//  cfg_wait_i in   4   wait states inserted before termination (sampled at request accept)
//  busy_o     out  1   1 while a request is accepted and not yet terminated/aborted
// BEHAVIOUR
//  Reset: wb_ack_o=0, wb_err_o=0, wb_dat_o=0, busy_o=0, FSM=IDLE, wait counter=0.
//   Memory contents not reset (undefined until written).
//  Request accepted in IDLE when cyc&stb=1; adr/we/sel/dat and cfg_wait_i registered that edge.
//  Decode (on accepted request, priority order):
//   adr==HOLE_ADDR                                   -> HOLE
//   adr[2:0]!=0 or adr[31:3+DEPTH_LOG2]!=BASE upper  -> error path
//   else                                             -> normal path, word = adr[3+DEPTH_LOG2-1:3]
//  FSM states IDLE, WAIT, RESP, HOLE:
//   IDLE -> WAIT if cfg_wait!=0 (counter loaded with cfg_wait), -> RESP if cfg_wait==0, -> HOLE.
//   WAIT: counter decrements per cycle; at counter==1 -> RESP. cyc=0 -> IDLE (abort).
//   RESP: ack (or err) high exactly this cycle; -> IDLE unconditionally.
//   HOLE: no termination ever; stays until cyc=0 -> IDLE.
//  Latency: stb sampled at edge N -> ack/err high in cycle N+1+cfg_wait. Min 2 cycles/transfer;
//   stb still high in the cycle after RESP is a new back-to-back request.
//  Write: memory updated on the edge ending RESP, only bytes with sel=1; sel=0 -> ack, no change.
//   Error-path and aborted writes never modify memory.
//  Read: wb_dat_o = stored word (all 8 bytes regardless of sel) during RESP, 0 otherwise.
//   err cycle: wb_dat_o=0. ack and err never high together.
//  Abort (cyc=0 during WAIT/HOLE): no ack/err generated, busy_o=0 next cycle.
//  cyc=0 in RESP: termination still issued (master ignores it); no memory side-effect change.
//  rst mid-transfer: pending write dropped, outputs to reset values next cycle.
//  busy_o = 1 in WAIT, RESP, HOLE.
// STRUCTURE
//  Shared package wb_pkg: bit8/bit32/bit64 typedefs, WB_DW=64, WB_SELW=8, WB_AW=32,
//   enum wb_slv_state_e {IDLE,WAIT,RESP,HOLE}.
//  Sub-module wb_mem_slave_ram: single-port 2**DEPTH_LOG2 x 64 array, 8-bit byte-write enables,
//   synchronous write, combinational-or-registered read timed to RESP.
//  Top holds decode, FSM, wait counter and output registers.
// TESTING
//  rst; cfg_wait=0; write adr 0x10 sel 0xFF dat 0x1122334455667788, read 0x10
//   -> ack 1 cycle after stb each, read 0x1122334455667788.
//  Partial write adr 0x10 sel 0x0F dat 0xAAAAAAAA_BBBBBBBB, read
//   -> 0x11223344_BBBBBBBB.
//  cfg_wait=5, read 0x10 -> ack exactly 6 cycles after stb sampled, busy_o high 6 cycles.
//  Write adr 0x0000_0803 (misaligned) and 0x0000_1000 (out of range, DEPTH_LOG2=8)
//   -> err one cycle, no ack, readback of word 0 unchanged.
//  Access HOLE_ADDR: no ack/err for 1000 cycles; drop cyc -> busy_o=0 next cycle, next read acks.
//  cfg_wait=3 write to 0x20, drop cyc after 2 cycles -> no ack, read 0x20 returns prior value;
//   rst asserted during WAIT -> ack/err stay 0, FSM IDLE.

Source files
------------

// File: rtl/wb_pkg.sv
// wb_pkg: shared Wishbone bus widths, data typedefs and the slave FSM state encoding.
package wb_pkg;
    localparam int WB_DW   = 64;
    localparam int WB_SELW = 8;
    localparam int WB_AW   = 32;
    typedef logic [7:0]  bit8;
    typedef logic [31:0] bit32;
    typedef logic [63:0] bit64;
    typedef enum logic [1:0] {IDLE, WAIT, RESP, HOLE} wb_slv_state_e;
endpackage

// File: rtl/wb_mem_slave_ram.sv
// wb_mem_slave_ram: single-port 64-bit word memory with byte write enables.
module wb_mem_slave_ram
    import wb_pkg::*;
#(
    parameter int DEPTH_LOG2 = 8
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [WB_SELW-1:0]    sel,
    input  logic [DEPTH_LOG2-1:0] addr,
    input  bit64                  wdata,
    output bit64                  rdata
);
    bit64 mem [0:2**DEPTH_LOG2-1];
    always_ff @(posedge clk)
        for (int i = 0; i < WB_SELW; i++)
            if (we && sel[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
    // Address is registered at request accept, so a combinational read is stable through RESP.
    assign rdata = mem[addr];
endmodule

// File: rtl/wb_mem_slave.sv
// wb_mem_slave: Wishbone B3 classic slave over a byte-enabled 64-bit memory,
// with programmable wait states, an error path and a never-acknowledging hole address.
module wb_mem_slave
    import wb_pkg::*;
#(
    parameter int   DEPTH_LOG2 = 8,
    parameter bit32 BASE_ADDR  = 32'h0000_0000,
    parameter bit32 HOLE_ADDR  = 32'hFFFF_FFF8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               wb_cyc_i,
    input  logic               wb_stb_i,
    input  logic               wb_we_i,
    input  logic [WB_AW-1:0]   wb_adr_i,
    input  logic [WB_SELW-1:0] wb_sel_i,
    input  logic [WB_DW-1:0]   wb_dat_i,
    output logic [WB_DW-1:0]   wb_dat_o,
    output logic               wb_ack_o,
    output logic               wb_err_o,
    input  logic [3:0]         cfg_wait_i,
    output logic               busy_o
);
    localparam int LO = 3 + DEPTH_LOG2;
    wb_slv_state_e state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic we_q, err_q, ram_we, resp;
    logic [WB_SELW-1:0] sel_q;
    logic [DEPTH_LOG2-1:0] word_q;
    bit64 dat_q, rdata;
    logic req, hole, bad;
    assign req  = state_q == IDLE && wb_cyc_i && wb_stb_i;
    assign hole = wb_adr_i == HOLE_ADDR;
    assign bad  = |wb_adr_i[2:0] || wb_adr_i[WB_AW-1:LO] != BASE_ADDR[WB_AW-1:LO];
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end
    always_ff @(posedge clk) begin
        if (req) begin
            we_q   <= wb_we_i;
            err_q  <= bad;
            sel_q  <= wb_sel_i;
            dat_q  <= wb_dat_i;
            word_q <= wb_adr_i[LO-1:3];
        end
    end
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: if (req) begin
                state_d = hole ? HOLE : (cfg_wait_i != '0 ? WAIT : RESP);
                cnt_d   = cfg_wait_i;
            end
            WAIT: begin
                cnt_d   = cnt_q - 4'd1;
                state_d = !wb_cyc_i ? IDLE : (cnt_q == 4'd1 ? RESP : WAIT);
            end
            RESP:    state_d = IDLE;
            HOLE:    state_d = wb_cyc_i ? HOLE : IDLE;
            default: state_d = IDLE;
        endcase
    end
    always_comb begin
        resp     = state_q == RESP;
        wb_ack_o = resp && !err_q;
        wb_err_o = resp && err_q;
        wb_dat_o = (resp && !err_q && !we_q) ? rdata : '0;
        busy_o   = state_q != IDLE;
        // A reset landing on RESP must drop the pending write.
        ram_we   = resp && we_q && !err_q && !rst;
    end
    wb_mem_slave_ram #(.DEPTH_LOG2(DEPTH_LOG2)) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .sel   (sel_q),
        .addr  (word_q),
        .wdata (dat_q),
        .rdata (rdata)
    );
endmodule

// File: tb/tb_wb_mem_slave.sv
// tb_wb_mem_slave: scoreboard bench; the driver pushes expected terminations from a
// byte-array memory model, and a monitor pops and compares on every ack/err.
module tb_wb_mem_slave;
    localparam logic [31:0] HOLE = 32'hFFFF_FFF8;
    typedef struct {
        bit          err;
        bit          chk_dat;
        logic [63:0] dat;
        int          due;
    } exp_t;
    logic        clk = 0, rst = 1;
    logic        cyc = 0, stb = 0, we = 0;
    logic [31:0] adr = 0;
    logic [7:0]  sel = 0;
    logic [63:0] dat_i = 0, dat_o;
    logic        ack, err, busy;
    logic [3:0]  cfg_wait = 0;
    int          total = 0, passed = 0, cyc_n = 0, terms = 0;
    exp_t        q[$];
    logic [7:0]  ref_mem [0:2047];
    wb_mem_slave dut (
        .clk(clk), .rst(rst), .wb_cyc_i(cyc), .wb_stb_i(stb), .wb_we_i(we),
        .wb_adr_i(adr), .wb_sel_i(sel), .wb_dat_i(dat_i), .wb_dat_o(dat_o),
        .wb_ack_o(ack), .wb_err_o(err), .cfg_wait_i(cfg_wait), .busy_o(busy)
    );
    always #5 clk = ~clk;
    always @(posedge clk) cyc_n++;
    task automatic chk(input bit ok, input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (ok) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask
    function automatic logic [63:0] ref_word(input int base);
        logic [63:0] w;
        for (int b = 0; b < 8; b++) w[8*b +: 8] = ref_mem[base + b];
        return w;
    endfunction
    always @(negedge clk) begin
        if (ack || err) begin
            exp_t e;
            terms++;
            chk(!(ack && err), "ack_err_exclusive", {ack, err}, 2'b00);
            if (q.size() == 0) chk(0, "unexpected_termination", {ack, err}, 0);
            else begin
                e = q.pop_front();
                chk(err == e.err, "term_kind_err", err, e.err);
                chk(cyc_n == e.due, "term_latency", cyc_n, e.due);
                if (e.chk_dat) chk(dat_o == e.dat, "read_data", dat_o, e.dat);
            end
        end
    end
    task automatic xfer(input bit w_en, input logic [31:0] a, input logic [7:0] s,
                        input logic [63:0] d, input logic [3:0] w, output int busy_n);
        exp_t e;
        bit done = 0;
        @(negedge clk);
        cyc = 1; stb = 1; we = w_en; adr = a; sel = s; dat_i = d; cfg_wait = w;
        e.err     = a % 8 != 0 || a >= 32'h800;
        e.due     = cyc_n + 1 + int'(w);
        e.chk_dat = e.err || !w_en;
        e.dat     = (e.err || w_en) ? 64'd0 : ref_word(int'(a));
        if (!e.err && w_en)
            for (int b = 0; b < 8; b++) if (s[b]) ref_mem[int'(a) + b] = d[8*b +: 8];
        q.push_back(e);
        busy_n = 0;
        for (int i = 0; i < 40 && !done; i++) begin
            @(negedge clk);
            busy_n += int'(busy);
            done = ack || err;
        end
        chk(done, "xfer_timeout", done, 1);
        cyc = 0; stb = 0;
    endtask
    initial begin
        int bn, t0;
        logic [31:0] a;
        repeat (3) @(negedge clk);
        chk(ack == 0, "reset_ack", ack, 0);
        chk(err == 0, "reset_err", err, 0);
        chk(dat_o == 0, "reset_dat", dat_o, 0);
        chk(busy == 0, "reset_busy", busy, 0);
        rst = 0;
        xfer(1, 32'h10, 8'hFF, 64'h1122334455667788, 0, bn);
        xfer(0, 32'h10, 8'hFF, 0, 0, bn);
        xfer(1, 32'h10, 8'h0F, 64'hAAAAAAAA_BBBBBBBB, 0, bn);
        xfer(0, 32'h10, 8'h00, 0, 0, bn);
        chk(ref_word(16) == 64'h11223344_BBBBBBBB, "model_partial", ref_word(16), 64'h11223344_BBBBBBBB);
        xfer(0, 32'h10, 8'hFF, 0, 5, bn);
        chk(bn == 6, "busy_cycles_wait5", bn, 6);
        xfer(1, 32'h10, 8'h00, 64'hDEAD, 0, bn);
        xfer(0, 32'h10, 8'hFF, 0, 0, bn);
        xfer(1, 32'h0, 8'hFF, 64'h0123456789ABCDEF, 1, bn);
        xfer(1, 32'h803, 8'hFF, 64'hFFFF_FFFF_FFFF_FFFF, 0, bn);
        xfer(1, 32'h1000, 8'hFF, 64'hFFFF_FFFF_FFFF_FFFF, 2, bn);
        xfer(1, 32'h5, 8'hFF, 64'hFFFF_FFFF_FFFF_FFFF, 0, bn);
        xfer(0, 32'h0, 8'hFF, 0, 0, bn);
        @(negedge clk);
        cyc = 1; stb = 1; we = 0; adr = HOLE; cfg_wait = 0;
        t0 = terms;
        repeat (1000) @(negedge clk);
        chk(terms == t0, "hole_no_termination", terms, t0);
        chk(busy == 1, "hole_busy", busy, 1);
        cyc = 0; stb = 0;
        @(negedge clk);
        chk(busy == 0, "hole_abort_busy", busy, 0);
        xfer(0, 32'h10, 8'hFF, 0, 0, bn);
        xfer(1, 32'h20, 8'hFF, 64'hCAFEF00D_12345678, 0, bn);
        @(negedge clk);
        cyc = 1; stb = 1; we = 1; adr = 32'h20; sel = 8'hFF; dat_i = 64'h5555; cfg_wait = 3;
        t0 = terms;
        repeat (2) @(negedge clk);
        cyc = 0; stb = 0;
        @(negedge clk);
        chk(busy == 0, "abort_busy", busy, 0);
        repeat (4) @(negedge clk);
        chk(terms == t0, "abort_no_termination", terms, t0);
        xfer(0, 32'h20, 8'hFF, 0, 0, bn);
        @(negedge clk);
        cyc = 1; stb = 1; we = 1; adr = 32'h20; sel = 8'hFF; dat_i = 64'h7777; cfg_wait = 5;
        t0 = terms;
        repeat (2) @(negedge clk);
        rst = 1;
        @(negedge clk);
        chk(ack == 0 && err == 0, "rst_mid_term", {ack, err}, 0);
        chk(busy == 0, "rst_mid_busy", busy, 0);
        cyc = 0; stb = 0; rst = 0;
        repeat (8) @(negedge clk);
        chk(terms == t0, "rst_no_termination", terms, t0);
        xfer(0, 32'h20, 8'hFF, 0, 0, bn);
        for (int i = 0; i < 16; i++)
            xfer(1, 32'(i * 8), 8'hFF, {$urandom, $urandom}, 4'($urandom_range(0, 2)), bn);
        for (int i = 0; i < 150; i++) begin
            int r = $urandom_range(0, 15);
            a = 32'($urandom_range(0, 15) * 8);
            if (r == 0) a = a + 32'($urandom_range(1, 7));
            else if (r == 1) a = 32'h800 + 32'($urandom_range(0, 4095) * 8);
            xfer(1'($urandom), a, 8'($urandom), {$urandom, $urandom}, 4'($urandom_range(0, 4)), bn);
            chk(bn == 0 || bn >= 1, "busy_seen", bn, 1);
        end
        repeat (3) @(negedge clk);
        chk(q.size() == 0, "scoreboard_drained", q.size(), 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
